// File: rtl/cache_sequencer.sv
// cache_sequencer: the only owner of the data-cache BRAM port.
// LOAD streams external words into the cache. READ gathers NUM_FMA consecutive
// words into one vector for the data buffer. WRITE stores an FMA result vector.
//
// Handshakes (cmd, ext, buf): a transfer happens on a rising clk_in edge where
// valid and ready are both high. A source holding valid keeps its payload steady
// until that edge. fma_valid_in is a one-cycle strobe with no ready.
//
// Every output is a register. state_out exposes the FSM state for debug.
module cache_sequencer #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_FMA      = 4,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          cmd_valid_in,
  output logic                          cmd_ready_out,
  input  logic [1:0]                    cmd_op_in,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_in,
  input  logic [ADDR_WIDTH:0]           cmd_len_in,
  input  logic [DATA_WIDTH-1:0]         ext_data_in,
  input  logic                          ext_valid_in,
  output logic                          ext_ready_out,
  input  logic [NUM_FMA*DATA_WIDTH-1:0] fma_result_in,
  input  logic                          fma_valid_in,
  output logic [NUM_FMA*DATA_WIDTH-1:0] buf_data_out,
  output logic                          buf_valid_out,
  input  logic                          buf_ready_in,
  output logic [ADDR_WIDTH-1:0]         bram_addr_out,
  output logic                          bram_we_out,
  output logic [DATA_WIDTH-1:0]         bram_din_out,
  input  logic [DATA_WIDTH-1:0]         bram_dout_in,
  output logic                          err_out,
  output logic [2:0]                    state_out
);

  localparam int VW = NUM_FMA * DATA_WIDTH;
  localparam int LW = (NUM_FMA > 1) ? $clog2(NUM_FMA) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] RD_ISSUE = 3'd2;
  localparam logic [2:0] RD_DRAIN = 3'd3;
  localparam logic [2:0] RD_HOLD  = 3'd4;
  localparam logic [2:0] WR_WAIT  = 3'd5;
  localparam logic [2:0] WR_ISSUE = 3'd6;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [ADDR_WIDTH:0] NF_CNT    = (ADDR_WIDTH+1)'(NUM_FMA);
  localparam logic [LW-1:0]       LAST_LANE = LW'(NUM_FMA - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len_q;
  // cnt is the word count in LOAD, and the next lane to issue in RD_ISSUE and WR_ISSUE.
  logic [ADDR_WIDTH:0]   cnt;
  // Lanes still waiting to be written. Shifted down one lane per write cycle.
  logic [VW-1:0]         wr_vec;

  // issue_* is aligned with bram_addr_out (the address is on the bus this cycle).
  // rd_sr_* delays it by BRAM_LATENCY cycles so it lines up with bram_dout_in.
  logic                  issue_vld;
  logic [LW-1:0]         issue_lane;
  logic [BRAM_LATENCY-1:0] rd_sr_vld;
  logic [LW-1:0]         rd_sr_lane [BRAM_LATENCY];

  assign state_out = state;

  // Read-return tracking: shift the issue tag along to the cycle its data arrives.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_sr_vld <= '0;
      for (int k = 0; k < BRAM_LATENCY; k++) rd_sr_lane[k] <= '0;
    end else begin
      rd_sr_vld[0]  <= issue_vld;
      rd_sr_lane[0] <= issue_lane;
      for (int k = 1; k < BRAM_LATENCY; k++) begin
        rd_sr_vld[k]  <= rd_sr_vld[k-1];
        rd_sr_lane[k] <= rd_sr_lane[k-1];
      end
    end
  end

  // Main FSM. It also drives every registered output and the BRAM port.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cmd_ready_out <= 1'b1;
      ext_ready_out <= 1'b0;
      buf_valid_out <= 1'b0;
      buf_data_out  <= '0;
      bram_addr_out <= '0;
      bram_we_out   <= 1'b0;
      bram_din_out  <= '0;
      err_out       <= 1'b0;
      base_addr     <= '0;
      len_q         <= '0;
      cnt           <= '0;
      wr_vec        <= '0;
      issue_vld     <= 1'b0;
      issue_lane    <= '0;
    end else begin
      bram_we_out <= 1'b0;
      err_out     <= 1'b0;
      issue_vld   <= 1'b0;

      // Returning read data goes into the lane that its tag names.
      if (rd_sr_vld[BRAM_LATENCY-1])
        buf_data_out[int'(rd_sr_lane[BRAM_LATENCY-1])*DATA_WIDTH +: DATA_WIDTH] <= bram_dout_in;

      case (state)
        IDLE: begin
          if (cmd_valid_in && cmd_ready_out) begin
            base_addr <= cmd_addr_in;
            len_q     <= cmd_len_in;
            cnt       <= '0;
            case (cmd_op_in)
              OP_LOAD: begin
                // A zero-length LOAD finishes at once, so the sequencer stays ready.
                if (cmd_len_in != '0) begin
                  state         <= LOAD;
                  cmd_ready_out <= 1'b0;
                  ext_ready_out <= 1'b1;
                end
              end
              OP_READ: begin
                // Issue lane 0 now, so its address is on the bus in the next cycle.
                state         <= RD_ISSUE;
                cmd_ready_out <= 1'b0;
                bram_addr_out <= cmd_addr_in;
                issue_vld     <= 1'b1;
                issue_lane    <= '0;
                cnt           <= (ADDR_WIDTH+1)'(1);
              end
              OP_WRITE: begin
                state         <= WR_WAIT;
                cmd_ready_out <= 1'b0;
              end
              default: err_out <= 1'b1;
            endcase
          end
        end

        LOAD: begin
          if (ext_valid_in) begin
            bram_we_out   <= 1'b1;
            bram_addr_out <= base_addr + cnt[ADDR_WIDTH-1:0];
            bram_din_out  <= ext_data_in;
            cnt           <= cnt + 1'b1;
            if ((cnt + 1'b1) == len_q) begin
              state         <= IDLE;
              cmd_ready_out <= 1'b1;
              ext_ready_out <= 1'b0;
            end
          end
        end

        RD_ISSUE: begin
          if (cnt == NF_CNT) begin
            state <= RD_DRAIN;
          end else begin
            bram_addr_out <= base_addr + cnt[ADDR_WIDTH-1:0];
            issue_vld     <= 1'b1;
            issue_lane    <= cnt[LW-1:0];
            cnt           <= cnt + 1'b1;
          end
        end

        RD_DRAIN: begin
          // The vector is complete on the edge that captures the last lane.
          if (rd_sr_vld[BRAM_LATENCY-1] && rd_sr_lane[BRAM_LATENCY-1] == LAST_LANE) begin
            buf_valid_out <= 1'b1;
            state         <= RD_HOLD;
          end
        end

        RD_HOLD: begin
          if (buf_ready_in) begin
            buf_valid_out <= 1'b0;
            cmd_ready_out <= 1'b1;
            state         <= IDLE;
          end
        end

        WR_WAIT: begin
          // Write lane 0 right away and keep the other lanes for the next cycles.
          if (fma_valid_in) begin
            bram_we_out   <= 1'b1;
            bram_addr_out <= base_addr;
            bram_din_out  <= fma_result_in[DATA_WIDTH-1:0];
            wr_vec        <= fma_result_in >> DATA_WIDTH;
            cnt           <= (ADDR_WIDTH+1)'(1);
            state         <= WR_ISSUE;
          end
        end

        WR_ISSUE: begin
          if (cnt == NF_CNT) begin
            state         <= IDLE;
            cmd_ready_out <= 1'b1;
          end else begin
            bram_we_out   <= 1'b1;
            bram_addr_out <= base_addr + cnt[ADDR_WIDTH-1:0];
            bram_din_out  <= wr_vec[DATA_WIDTH-1:0];
            wr_vec        <= wr_vec >> DATA_WIDTH;
            cnt           <= cnt + 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          cmd_ready_out <= 1'b1;
          ext_ready_out <= 1'b0;
          buf_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sequencer.sv
// tb_cache_sequencer: directed, table-driven bench for cache_sequencer.
// Includes a latency-2 BRAM model, a scoreboard of expected BRAM writes,
// and hand-written sequences for the stray-input and mid-read reset cases.
`timescale 1ns/1ps
module tb_cache_sequencer;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int NF = 4;
  localparam int VW = NF * DW;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          cmd_valid_in = 1'b0;
  logic          cmd_ready_out;
  logic [1:0]    cmd_op_in = '0;
  logic [AW-1:0] cmd_addr_in = '0;
  logic [AW:0]   cmd_len_in = '0;
  logic [DW-1:0] ext_data_in = '0;
  logic          ext_valid_in = 1'b0;
  logic          ext_ready_out;
  logic [VW-1:0] fma_result_in = '0;
  logic          fma_valid_in = 1'b0;
  logic [VW-1:0] buf_data_out;
  logic          buf_valid_out;
  logic          buf_ready_in = 1'b0;
  logic [AW-1:0] bram_addr_out;
  logic          bram_we_out;
  logic [DW-1:0] bram_din_out;
  logic [DW-1:0] bram_dout_in;
  logic          err_out;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected the test to finish earlier");
    $fatal(1, "watchdog");
  end

  cache_sequencer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_op_in     (cmd_op_in),
    .cmd_addr_in   (cmd_addr_in),
    .cmd_len_in    (cmd_len_in),
    .ext_data_in   (ext_data_in),
    .ext_valid_in  (ext_valid_in),
    .ext_ready_out (ext_ready_out),
    .fma_result_in (fma_result_in),
    .fma_valid_in  (fma_valid_in),
    .buf_data_out  (buf_data_out),
    .buf_valid_out (buf_valid_out),
    .buf_ready_in  (buf_ready_in),
    .bram_addr_out (bram_addr_out),
    .bram_we_out   (bram_we_out),
    .bram_din_out  (bram_din_out),
    .bram_dout_in  (bram_dout_in),
    .err_out       (err_out),
    .state_out     (state_dbg)
  );

  // ---------------- BRAM model: two-cycle read latency ----------------
  logic          mem_init = 1'b1;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_p1;

  always @(posedge clk_in) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (bram_we_out) begin
      mem[bram_addr_out] <= bram_din_out;
    end
    rd_p1        <= mem[bram_addr_out];
    bram_dout_in <= rd_p1;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_exp;

  // Every observed BRAM write must match the next expected {addr, data}.
  always @(negedge clk_in) begin
    if (!rst_in && bram_we_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", bram_addr_out, bram_din_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("bram_write", {bram_addr_out, bram_din_out}, mon_exp);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    logic [DW-1:0] dbase;   // LOAD words are dbase, dbase+1, ...
    int            gap;     // idle ext cycles inserted before LOAD word 2
    logic [VW-1:0] fma;
    int            delay;   // fma_valid_in is driven in cycle T+delay
    logic [VW-1:0] exp_buf;
    int            hold;    // cycles buf_ready_in stays low after valid
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW:0] len);
    @(negedge clk_in);
    check("cmd_ready_idle", cmd_ready_out, 1);
    cmd_valid_in = 1'b1;
    cmd_op_in    = op;
    cmd_addr_in  = addr;
    cmd_len_in   = len;
    @(posedge clk_in);
    #1 cmd_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (cmd_ready_out !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    check(name, cmd_ready_out, 1);
  endtask

  task automatic drain_check(input string name);
    repeat (2) @(negedge clk_in);
    check(name, exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    case (v.op)
      OP_LOAD: begin
        for (int k = 0; k < int'(v.len); k++)
          exp_q.push_back({AW'(v.addr + k), DW'(v.dbase + k)});
        send_cmd(OP_LOAD, v.addr, v.len);
        if (v.len == 0) begin
          @(negedge clk_in);
          check("load0_cmd_ready", cmd_ready_out, 1);
          check("load0_ext_ready", ext_ready_out, 0);
        end else begin
          for (int k = 0; k < int'(v.len); k++) begin
            if (k == 2) repeat (v.gap) @(negedge clk_in);
            @(negedge clk_in);
            check("load_ext_ready", ext_ready_out, 1);
            ext_valid_in = 1'b1;
            ext_data_in  = DW'(v.dbase + k);
            @(posedge clk_in);
            #1 ext_valid_in = 1'b0;
          end
          @(negedge clk_in);
          wait_idle("load_done_ready");
          check("load_done_ext_ready", ext_ready_out, 0);
        end
        drain_check("load_writes_drained");
      end
      OP_READ: begin
        send_cmd(OP_READ, v.addr, '0);
        lat = 0;
        for (int c = 0; c < 30; c++) begin
          @(negedge clk_in);
          lat++;
          if (buf_valid_out) break;
        end
        check("read_latency", lat, 7);
        check("read_data", buf_data_out, v.exp_buf);
        check("read_cmd_busy", cmd_ready_out, 0);
        for (int h = 0; h < v.hold; h++) begin
          @(negedge clk_in);
          check("read_hold_valid", buf_valid_out, 1);
          check("read_hold_data", buf_data_out, v.exp_buf);
        end
        buf_ready_in = 1'b1;
        @(posedge clk_in);
        #1 buf_ready_in = 1'b0;
        @(negedge clk_in);
        check("read_done_valid", buf_valid_out, 0);
        check("read_done_ready", cmd_ready_out, 1);
      end
      OP_WRITE: begin
        for (int k = 0; k < NF; k++)
          exp_q.push_back({AW'(v.addr + k), v.fma[k*DW +: DW]});
        send_cmd(OP_WRITE, v.addr, '0);
        for (int d = 1; d < v.delay; d++) begin
          @(negedge clk_in);
          check("write_wait_we", bram_we_out, 0);
        end
        @(negedge clk_in);
        fma_valid_in  = 1'b1;
        fma_result_in = v.fma;
        @(posedge clk_in);
        #1 fma_valid_in = 1'b0;
        fma_result_in = {VW{1'b1}};
        for (int k = 0; k < NF; k++) begin
          @(negedge clk_in);
          check("write_consecutive_we", bram_we_out, 1);
        end
        @(negedge clk_in);
        wait_idle("write_done_ready");
        drain_check("write_writes_drained");
      end
      default: begin
        send_cmd(OP_ILL, v.addr, v.len);
        @(negedge clk_in);
        check("illegal_err_pulse", err_out, 1);
        check("illegal_stays_ready", cmd_ready_out, 1);
        check("illegal_no_we", bram_we_out, 0);
        @(negedge clk_in);
        check("illegal_err_cleared", err_out, 0);
      end
    endcase
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    tbl[0]  = '{OP_LOAD,  11'h010, 12'd5, 16'h00A0, 2, 64'h0, 0, 64'h0, 0};
    tbl[1]  = '{OP_LOAD,  11'h100, 12'd4, 16'h0001, 0, 64'h0, 0, 64'h0, 0};
    tbl[2]  = '{OP_READ,  11'h100, 12'd0, 16'h0, 0, 64'h0, 0, 64'h0004_0003_0002_0001, 5};
    tbl[3]  = '{OP_WRITE, 11'h200, 12'd0, 16'h0, 0, 64'h000D_000C_000B_000A, 3, 64'h0, 0};
    tbl[4]  = '{OP_READ,  11'h200, 12'd0, 16'h0, 0, 64'h0, 0, 64'h000D_000C_000B_000A, 0};
    tbl[5]  = '{OP_LOAD,  11'h7FE, 12'd4, 16'h0050, 0, 64'h0, 0, 64'h0, 0};
    tbl[6]  = '{OP_READ,  11'h7FE, 12'd0, 16'h0, 0, 64'h0, 0, 64'h0053_0052_0051_0050, 1};
    tbl[7]  = '{OP_LOAD,  11'h300, 12'd0, 16'h0, 0, 64'h0, 0, 64'h0, 0};
    tbl[8]  = '{OP_ILL,   11'h123, 12'd3, 16'h0, 0, 64'h0, 0, 64'h0, 0};
    tbl[9]  = '{OP_READ,  11'h010, 12'd0, 16'h0, 0, 64'h0, 0, 64'h00A3_00A2_00A1_00A0, 2};
    tbl[10] = '{OP_WRITE, 11'h7FF, 12'd0, 16'h0, 0, 64'h4444_3333_2222_1111, 1, 64'h0, 0};
    tbl[11] = '{OP_READ,  11'h000, 12'd0, 16'h0, 0, 64'h0, 0, 64'h0000_4444_3333_2222, 0};

    // Reset state.
    repeat (3) @(negedge clk_in);
    check("reset_cmd_ready", cmd_ready_out, 1);
    check("reset_ext_ready", ext_ready_out, 0);
    check("reset_buf_valid", buf_valid_out, 0);
    check("reset_buf_data", buf_data_out, 0);
    check("reset_bram_we", bram_we_out, 0);
    check("reset_bram_addr", bram_addr_out, 0);
    check("reset_bram_din", bram_din_out, 0);
    check("reset_err", err_out, 0);
    check("reset_state", state_dbg, 0);
    rst_in   = 1'b0;
    mem_init = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(tbl[i]);

    // Stray ext/fma strobes in IDLE must not produce writes.
    @(negedge clk_in);
    ext_valid_in  = 1'b1;
    ext_data_in   = 16'hBEEF;
    fma_valid_in  = 1'b1;
    fma_result_in = 64'hDEAD_DEAD_DEAD_DEAD;
    repeat (3) begin
      @(negedge clk_in);
      check("stray_ext_ready", ext_ready_out, 0);
      check("stray_we", bram_we_out, 0);
    end
    ext_valid_in = 1'b0;
    fma_valid_in = 1'b0;
    @(negedge clk_in);
    check("stray_cmd_ready", cmd_ready_out, 1);

    // Reset in the middle of a READ (drain phase); lanes 0 and 1 are already captured.
    send_cmd(OP_READ, 11'h100, '0);
    repeat (4) @(negedge clk_in);
    check("midread_busy", cmd_ready_out, 0);
    check("midread_not_valid", buf_valid_out, 0);
    rst_in = 1'b1;
    #1;
    check("rst_async_cmd_ready", cmd_ready_out, 1);
    check("rst_async_buf_valid", buf_valid_out, 0);
    check("rst_async_buf_data", buf_data_out, 0);
    check("rst_async_bram_addr", bram_addr_out, 0);
    check("rst_async_bram_we", bram_we_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_release_ready", cmd_ready_out, 1);
    check("rst_release_valid", buf_valid_out, 0);
    rv = '{OP_READ, 11'h200, 12'd0, 16'h0, 0, 64'h0, 0, 64'h000D_000C_000B_000A, 1};
    run_vec(rv);

    repeat (3) @(negedge clk_in);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
